// File: rtl/userid_enroll_pkg.sv
// Shared definitions for the user-ID enroll and lookup controllers:
// FSM encoding, default widths and the empty-slot marker.
package userid_enroll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT1  = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_WRITE  = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam int ID_W_DEF   = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int RD_LAT_DEF = 2;
    localparam int EMPTY_ID   = 0;

    // Cycles spent in WAIT2 beyond its first clock for a given read latency.
    function automatic int extra_wait(input int rd_lat);
        return (rd_lat > 2) ? rd_lat - 2 : 0;
    endfunction

endpackage

// File: rtl/userid_enroll_controller.sv
// Enroll FSM: scans a packed ID table from slot 0, stops on a duplicate,
// the first empty slot (then writes the ID there) or a full table.
module userid_enroll_controller
    import userid_enroll_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enroll_req,
    input  logic [ID_W-1:0]   userID_in,
    input  logic [ID_W-1:0]   q_in,
    output logic [ADDR_W-1:0] address_out,
    output logic [ID_W-1:0]   data_out,
    output logic              wren,
    output logic              done,
    output logic              enrolledFlag,
    output logic              duplicateFlag,
    output logic              fullFlag,
    output state_e            o_state_dbg
);

    localparam logic [ID_W-1:0]   EMPTY     = ID_W'(EMPTY_ID);
    localparam logic [ADDR_W-1:0] LAST_SLOT = '1;
    localparam logic [7:0]        WAIT2_END = 8'(extra_wait(RD_LAT));

    // Handshake: enroll_req is a level held by the requester until it sees
    // done; dropping it in FINISH returns to IDLE and done falls next clock.
    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_data;
    logic              r_wren;
    logic              r_done;
    logic              r_enrolled;
    logic              r_duplicate;
    logic              r_full;
    logic [7:0]        r_wait_cnt;
    logic              w_accept;

    assign w_accept = enroll_req && (userID_in != EMPTY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_wren      <= 1'b0;
            r_done      <= 1'b0;
            r_enrolled  <= 1'b0;
            r_duplicate <= 1'b0;
            r_full      <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_addr <= '0;
                    r_wren <= 1'b0;
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_data      <= userID_in;
                        r_enrolled  <= 1'b0;
                        r_duplicate <= 1'b0;
                        r_full      <= 1'b0;
                        r_state     <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (r_wait_cnt == WAIT2_END) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_CHECK: begin
                    // Match beats empty so an existing ID is never written twice.
                    if (q_in == r_data) begin
                        r_duplicate <= 1'b1;
                        r_done      <= 1'b1;
                        r_state     <= ST_FINISH;
                    end else if (q_in == EMPTY) begin
                        r_wren  <= 1'b1;
                        r_state <= ST_WRITE;
                    end else if (r_addr == LAST_SLOT) begin
                        r_full  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= ST_WAIT1;
                    end
                end
                ST_WRITE: begin
                    r_wren     <= 1'b0;
                    r_enrolled <= 1'b1;
                    r_done     <= 1'b1;
                    r_state    <= ST_FINISH;
                end
                ST_FINISH: begin
                    if (!enroll_req) begin
                        r_done  <= 1'b0;
                        r_addr  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_wren  <= 1'b0;
                    r_done  <= 1'b0;
                    r_addr  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign address_out   = r_addr;
    assign data_out      = r_data;
    assign wren          = r_wren;
    assign done          = r_done;
    assign enrolledFlag  = r_enrolled;
    assign duplicateFlag = r_duplicate;
    assign fullFlag      = r_full;
    assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_userid_enroll_controller.sv
// Directed bench for userid_enroll_controller with a 2-cycle-latency table
// model and a done-triggered scoreboard.
module tb_userid_enroll_controller;
    import userid_enroll_pkg::*;

    localparam int W = 40;

    logic        clk;
    logic        rst;
    logic        enroll_req;
    logic [15:0] userID_in;
    logic [15:0] q_in;
    logic [3:0]  address_out;
    logic [15:0] data_out;
    logic        wren;
    logic        done;
    logic        enrolledFlag;
    logic        duplicateFlag;
    logic        fullFlag;
    state_e      state_dbg;

    userid_enroll_controller dut (
        .clk          (clk),
        .rst          (rst),
        .enroll_req   (enroll_req),
        .userID_in    (userID_in),
        .q_in         (q_in),
        .address_out  (address_out),
        .data_out     (data_out),
        .wren         (wren),
        .done         (done),
        .enrolledFlag (enrolledFlag),
        .duplicateFlag(duplicateFlag),
        .fullFlag     (fullFlag),
        .o_state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- table model: RD_LAT = 2 ----------------
    logic [15:0] mem [16];
    logic [15:0] pipe1;

    always @(posedge clk) begin
        pipe1 <= mem[address_out];
        q_in  <= pipe1;
        if (wren) mem[address_out] <= data_out;
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
    endtask

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected packing: {pad3, lat8, data16, wr_addr4, wcnt2, addr4, enr, dup, full}
    function automatic logic [W-1:0] mk(input logic enr, input logic dup, input logic full,
                                        input logic [3:0] addr, input logic [1:0] wcnt,
                                        input logic [3:0] wa, input logic [15:0] d,
                                        input logic [7:0] lat);
        return {3'b000, lat, d, wa, wcnt, addr, enr, dup, full};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    logic         prev_done = 1'b0;
    int           wcnt = 0;
    logic [3:0]   wr_addr = '0;
    logic [15:0]  wr_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            wcnt      = 0;
            prev_done = 1'b0;
        end else begin
            if (wren) begin
                wcnt++;
                wr_addr = address_out;
                wr_data = data_out;
            end
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("flags", 64'({enrolledFlag, duplicateFlag, fullFlag}), 64'(e[2:0]));
                    check("final_addr", 64'(address_out), 64'(e[6:3]));
                    check("wren_count", 64'(wcnt), 64'(e[8:7]));
                    check("data_out", 64'(data_out), 64'(e[28:13]));
                    check("latency", 64'(cyc - start_cyc), 64'(e[36:29]));
                    if (e[8:7] != 2'd0) begin
                        check("wr_addr", 64'(wr_addr), 64'(e[12:9]));
                        check("wr_data", 64'(wr_data), 64'(e[28:13]));
                        check("mem_written", 64'(mem[wr_addr]), 64'(e[28:13]));
                    end
                end
                wcnt = 0;
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_enroll(input logic [15:0] id, input logic [W-1:0] expv,
                              input int chg_at, input logic [15:0] chg_id);
        bit seen = 0;
        exp_q.push_back(expv);
        @(negedge clk);
        userID_in  = id;
        enroll_req = 1'b1;
        start_cyc  = cyc;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (n == chg_at) userID_in = chg_id;
            if (done) seen = 1;
        end
        check("done_within_bound", 64'(seen), 64'(1));
        enroll_req = 1'b0;
        @(negedge clk);
        check("done_falls", 64'(done), 64'(0));
        check("back_idle", 64'(state_dbg), 64'(ST_IDLE));
        check("idle_addr", 64'(address_out), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit hit;
        rst        = 1'b0;
        enroll_req = 1'b0;
        userID_in  = 16'h0;
        clear_mem();
        #3;
        check("rst_addr", 64'(address_out), 64'(0));
        check("rst_outs", 64'({wren, done, enrolledFlag, duplicateFlag, fullFlag}), 64'(0));
        check("rst_data", 64'(data_out), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Empty table: write at slot 0 after 5 clocks.
        run_enroll(16'h1234, mk(1, 0, 0, 4'd0, 2'd1, 4'd0, 16'h1234, 8'd5), -1, 16'h0);

        // Two entries: write at slot 2.
        clear_mem();
        mem[0] <= 16'h0AAA;
        mem[1] <= 16'h0BBB;
        run_enroll(16'h0CCC, mk(1, 0, 0, 4'd2, 2'd1, 4'd2, 16'h0CCC, 8'd11), -1, 16'h0);

        // Duplicate at slot 1: no write.
        clear_mem();
        mem[0] <= 16'h0AAA;
        mem[1] <= 16'h0BBB;
        run_enroll(16'h0BBB, mk(0, 1, 0, 4'd1, 2'd0, 4'd0, 16'h0BBB, 8'd7), -1, 16'h0);

        // Full table; userID_in changes mid-search to an ID that is present.
        for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
        run_enroll(16'h5555, mk(0, 0, 1, 4'd15, 2'd0, 4'd0, 16'h5555, 8'd49), 6, 16'h1003);

        // Reset in WAIT2 at address 3, request held: restart from slot 0.
        clear_mem();
        mem[0] <= 16'h0AAA;
        mem[1] <= 16'h0BBB;
        mem[2] <= 16'h0CCC;
        @(negedge clk);
        userID_in  = 16'h0DDD;
        enroll_req = 1'b1;
        hit = 0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(negedge clk);
            if (state_dbg == ST_WAIT2 && address_out == 4'd3) hit = 1;
        end
        check("reach_wait2_addr3", 64'(hit), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state", 64'(state_dbg), 64'(ST_IDLE));
        check("async_rst_addr", 64'(address_out), 64'(0));
        check("async_rst_outs", 64'({wren, done, enrolledFlag, duplicateFlag, fullFlag}), 64'(0));
        check("async_rst_data", 64'(data_out), 64'(0));
        @(negedge clk);
        exp_q.push_back(mk(1, 0, 0, 4'd3, 2'd1, 4'd3, 16'h0DDD, 8'd14));
        #2;
        rst       = 1'b1;
        start_cyc = cyc;
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            if (done) hit = 1;
        end
        check("restart_done_within_bound", 64'(hit), 64'(1));
        enroll_req = 1'b0;
        @(negedge clk);
        check("restart_done_falls", 64'(done), 64'(0));
        check("idle_flags_held", 64'({enrolledFlag, duplicateFlag, fullFlag}), 64'(3'b100));

        // Zero ID is ignored.
        userID_in  = 16'h0;
        enroll_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("zero_id_idle", 64'(state_dbg), 64'(ST_IDLE));
            check("zero_id_done", 64'(done), 64'(0));
        end
        check("zero_id_no_wren", 64'(wcnt), 64'(0));
        check("zero_id_flags_held", 64'({enrolledFlag, duplicateFlag, fullFlag}), 64'(3'b100));
        enroll_req = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
